// File: rtl/pipe_add_sub.sv
// rtl/pipe_add_sub.sv - carry-pipelined adder/subtractor with valid/ready flow control
module pipe_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic stall;

    // Stage inputs (_i) come from the ports for stage 0 and from the previous stage's registers (_r) otherwise
    logic [WIDTH-1:0] a_i [STAGES];
    logic [WIDTH-1:0] b_i [STAGES];
    logic [WIDTH-1:0] s_i [STAGES];
    logic             c_i [STAGES];
    logic             v_i [STAGES];

    logic [WIDTH-1:0] a_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic [WIDTH-1:0] s_r [STAGES];
    logic             c_r [STAGES];
    logic             v_r [STAGES];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign a_i[0] = A;
    assign b_i[0] = B ^ {WIDTH{sub}};
    assign c_i[0] = cin ^ sub;
    assign v_i[0] = in_valid;
    assign s_i[0] = '0;

    genvar k;
    generate
        for (k = 1; k < STAGES; k++) begin : link
            assign a_i[k] = a_r[k-1];
            assign b_i[k] = b_r[k-1];
            assign s_i[k] = s_r[k-1];
            assign c_i[k] = c_r[k-1];
            assign v_i[k] = v_r[k-1];
        end

        for (k = 0; k < STAGES; k++) begin : stage
            logic [SW:0]      psum;
            logic [WIDTH-1:0] s_nxt;

            assign psum = {1'b0, a_i[k][k*SW +: SW]} + {1'b0, b_i[k][k*SW +: SW]}
                        + {{SW{1'b0}}, c_i[k]};

            always_comb begin
                s_nxt              = s_i[k];
                s_nxt[k*SW +: SW]  = psum[SW-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r[k] <= 1'b0;
                    c_r[k] <= 1'b0;
                    a_r[k] <= '0;
                    b_r[k] <= '0;
                    s_r[k] <= '0;
                end else if (!stall) begin
                    v_r[k] <= v_i[k];
                    c_r[k] <= psum[SW];
                    a_r[k] <= a_i[k];
                    b_r[k] <= b_i[k];
                    s_r[k] <= s_nxt;
                end
            end

            // Flags are resolved while the top slice is summed so they register alongside S
            if (k == L) begin : flags
                always_ff @(posedge clk) begin
                    if (rst) begin
                        ovf  <= 1'b0;
                        zero <= 1'b0;
                    end else if (!stall) begin
                        ovf  <= (a_i[k][WIDTH-1] == b_i[k][WIDTH-1]) &&
                                (psum[SW-1] != a_i[k][WIDTH-1]);
                        zero <= (s_nxt == '0);
                    end
                end
            end
        end
    endgenerate

    assign S         = s_r[L];
    assign cout      = c_r[L];
    assign out_valid = v_r[L];

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth. WIDTH SHALL be an integer multiple of STAGES. Slice width SW = WIDTH/STAGES.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
REQ-004 SHALL have these data and control ports:
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- S  output  WIDTH  result.
- cout  output  1  raw carry out of MSB.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  S == 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.

Function
REQ-005 SHALL compute S = A + (B XOR {WIDTH{sub}}) + (cin XOR sub), modulo 2^WIDTH. cout SHALL be bit WIDTH of the full sum.
REQ-006 For sub=1: cin=0 gives A-B; cin=1 gives A-B-1. cout=1 means no borrow.
REQ-007 ovf SHALL be 1 when the effective operands (A, B XOR {WIDTH{sub}}) share a sign bit and S's sign bit differs from it.
REQ-008 zero SHALL be 1 when S == 0, regardless of cout.
REQ-009 Stage k (k = 0..STAGES-1) SHALL add slice k (bits k*SW+SW-1 : k*SW) using the carry registered from stage k-1. Stage 0 SHALL use cin XOR sub.
REQ-010 Upper operand slices SHALL be delay-registered so that each slice meets its carry in the correct stage. Lower result slices SHALL be delay-registered so that all of S emerges aligned.
REQ-011 A transfer in SHALL occur when in_valid && in_ready. A transfer out SHALL occur when out_valid && out_ready.
REQ-012 Latency SHALL be exactly STAGES cycles from an input transfer to out_valid=1, provided no stall occurs. Throughput SHALL be one operation per cycle.
REQ-013 Stall condition: stall = out_valid && !out_ready. While stalled, every pipeline register SHALL hold its value, in_ready SHALL be 0, and S/cout/ovf/zero SHALL remain stable.
REQ-014 in_ready SHALL equal !stall, combinationally.
REQ-015 Each stage SHALL carry a valid bit. Bubbles (invalid entries) SHALL advance when not stalled and SHALL never produce out_valid.
REQ-016 Any stall/valid pattern SHALL neither drop nor duplicate an operation. Result order SHALL equal input order.
REQ-017 When out_valid=0, S/cout/ovf/zero values are don't-care, but they SHALL NOT contain X after reset.
REQ-018 The sub and cin of each operation SHALL travel with that operation. Mixing add and sub in consecutive cycles SHALL be supported.

Reset
REQ-019 On rst=1 at a clock edge, all valid bits SHALL clear, and S, cout, ovf and zero SHALL be 0. In the next cycle, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-020 Reset mid-operation SHALL discard all in-flight operations. No result from before reset SHALL appear after it.
REQ-021 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification (WIDTH=64, STAGES=4, out_ready=1 unless stated)
REQ-022 Add: A=1005, B=69, cin=1, sub=0 -> after 4 cycles out_valid=1, S=1075, cout=0, ovf=0, zero=0.
REQ-023 Sub borrow: A=0, B=1, cin=0, sub=1 -> S=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Cross-slice carry wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0 -> S=0, cout=1, zero=1.
REQ-024 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> S=0x8000_0000_0000_0000, ovf=1, cout=0. A=0x8000_0000_0000_0000, B=1, sub -> S=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
REQ-025 Back-to-back with stall: issue 6 consecutive adds (i + 100i for i=1..6) and hold out_ready=0 for 3 cycles once the first result appears. Required: in_ready=0 during the stall, then results 101, 202, ..., 606 in order, each exactly once.
REQ-026 Reset mid-flight: issue 3 operations, assert rst one cycle later -> out_valid stays 0 for the following 4 cycles. Afterwards, a fresh 501+5002423 gives S=5002924 with 4-cycle latency.
